// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port SRAM between the instruction
// fetch port and the data (MEM stage) port. One access is in flight at a time.
// The address and control signals are registered and held until the SRAM acks
// or until the wait counter expires.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, contention
// alternates between the two ports. When it is undefined, data always wins.
//
// Handshake: a requester raises *_req together with its qualifiers and holds
// them stable until it sees its one-cycle *_ready pulse. The matching *_rdata
// is valid in that same cycle and then holds until the next pulse. On the SRAM
// side, sram_ce and the sram_* qualifiers stay constant from grant until the
// cycle in which sram_ack is sampled high. sram_ack is ignored while idle.
module unified_mem_arbiter #(
  parameter int MAX_WAIT = 15,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_sel,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [3:0]        sram_sel,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  input  logic              sram_ack,
  output logic              stallreq_o,
  output logic              err_o,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    D_ACC  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q;

  logic in_idle, in_acc;
  logic pick_d, start_d, start_if;
  logic hit, tmo, fin;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data port was granted last, 0 = fetch port was granted last
  logic last_grant_q;

  // Track the most recent winner so contention can alternate
  always_ff @(posedge clk) begin
    if (!rst)          last_grant_q <= 1'b0;
    else if (start_d)  last_grant_q <= 1'b1;
    else if (start_if) last_grant_q <= 1'b0;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: grant from IDLE, return to IDLE on ack or timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_d)       state_d = D_ACC;
        else if (start_if) state_d = IF_ACC;
      end
      IF_ACC, D_ACC: begin
        if (fin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/decode logic: arbitration choice, completion detect, stall request
  always_comb begin
    in_idle = (state_q == IDLE);
    in_acc  = (state_q == IF_ACC) || (state_q == D_ACC);
`ifdef ARB_ROUND_ROBIN_EN
    pick_d  = (d_req && if_req) ? ~last_grant_q : d_req;
`else
    pick_d  = d_req;
`endif
    start_d  = in_idle && pick_d;
    start_if = in_idle && if_req && !pick_d;
    hit      = in_acc && sram_ack;
    // An ack in the final counted cycle takes precedence over the timeout
    tmo      = in_acc && !sram_ack && (cnt_q == CNT_LAST);
    fin      = hit || tmo;
    stallreq_o = rst && ((if_req && !if_ready) || (d_req && !d_ready));
    state_dbg  = state_q;
  end

  // Datapath: SRAM command registers, wait counter, read-data and pulse registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_sel   <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      err_o    <= 1'b0;
      if (start_d) begin
        sram_ce    <= 1'b1;
        sram_we    <= d_we;
        sram_sel   <= d_sel;
        sram_addr  <= d_addr;
        sram_wdata <= d_wdata;
        cnt_q      <= '0;
      end else if (start_if) begin
        sram_ce    <= 1'b1;
        sram_we    <= 1'b0;
        sram_sel   <= 4'b1111;
        sram_addr  <= if_addr;
        sram_wdata <= '0;
        cnt_q      <= '0;
      end else if (fin) begin
        sram_ce <= 1'b0;
        cnt_q   <= '0;
        err_o   <= tmo;
        if (state_q == D_ACC) begin
          d_ready <= 1'b1;
          // Stores and timed-out loads return zero
          d_rdata <= (hit && !sram_we) ? sram_rdata : 32'h0;
        end else begin
          if_ready <= 1'b1;
          if_rdata <= hit ? sram_rdata : 32'h0;
        end
      end else if (in_acc) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed bench for unified_mem_arbiter.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_unified_mem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int MAX_WAIT = 15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_IF   = 2'd1;
  localparam logic [1:0] ST_D    = 2'd2;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_sel;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ready;
  logic              sram_ce;
  logic              sram_we;
  logic [3:0]        sram_sel;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic              sram_ack;
  logic              stallreq_o;
  logic              err_o;
  logic [1:0]        state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  bit rr_mode;

  // clock/reset block
  always #5 clk = ~clk;

  unified_mem_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_sel(sram_sel), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ack(sram_ack),
    .stallreq_o(stallreq_o), .err_o(err_o), .state_dbg(state_dbg)
  );

  task automatic test_reset;
    rst = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h40; d_addr = 32'h80; d_sel = 4'hF; d_wdata = 32'h0;
    sram_ack = 1'b0; sram_rdata = 32'h0;
    repeat (3) @(negedge clk);
    n_cmp++; if (sram_ce !== 1'b0) begin n_bad++; $display("FAIL rst_sram_ce got=%b exp=0", sram_ce); end
    n_cmp++; if (if_ready !== 1'b0 || d_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b%b exp=00", if_ready, d_ready); end
    n_cmp++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got=%h/%h exp=0", if_rdata, d_rdata); end
    n_cmp++; if (stallreq_o !== 1'b0) begin n_bad++; $display("FAIL rst_stall got=%b exp=0", stallreq_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b exp=0", err_o); end
    n_cmp++; if (state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
    n_cmp++; if (sram_addr !== 32'h0) begin n_bad++; $display("FAIL rst_sram_addr got=%h exp=0", sram_addr); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (state_dbg !== ST_D) begin n_bad++; $display("FAIL rst_first_grant got=%0d exp=2", state_dbg); end
    n_cmp++; if (sram_addr !== 32'h80) begin n_bad++; $display("FAIL rst_first_addr got=%h exp=80", sram_addr); end
    n_cmp++; if (stallreq_o !== 1'b1) begin n_bad++; $display("FAIL rst_stall_wait got=%b exp=1", stallreq_o); end
    sram_ack = 1'b1; sram_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    n_cmp++; if (d_ready !== 1'b1 || if_ready !== 1'b0) begin n_bad++; $display("FAIL rst_first_done got d/if=%b%b exp=10", d_ready, if_ready); end
    n_cmp++; if (d_rdata !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL rst_first_rdata got=%h exp=0badf00d", d_rdata); end
    // keep ack high while idle: it must be ignored
    d_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (d_ready !== 1'b0 || if_ready !== 1'b0 || sram_ce !== 1'b0) begin n_bad++; $display("FAIL idle_ack got rdy=%b%b ce=%b exp=000", d_ready, if_ready, sram_ce); end
    n_cmp++; if (state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL idle_ack_state got=%0d exp=0", state_dbg); end
    sram_ack = 1'b0;
  endtask

  task automatic test_fetch;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    #1;
    n_cmp++; if (stallreq_o !== 1'b1) begin n_bad++; $display("FAIL fetch_stall_req got=%b exp=1", stallreq_o); end
    @(negedge clk);
    n_cmp++; if (state_dbg !== ST_IF || sram_ce !== 1'b1) begin n_bad++; $display("FAIL fetch_grant got st=%0d ce=%b exp=1/1", state_dbg, sram_ce); end
    n_cmp++; if (sram_addr !== 32'h100 || sram_we !== 1'b0 || sram_sel !== 4'hF) begin n_bad++; $display("FAIL fetch_cmd got a=%h we=%b sel=%h exp=100/0/f", sram_addr, sram_we, sram_sel); end
    n_cmp++; if (stallreq_o !== 1'b1) begin n_bad++; $display("FAIL fetch_stall got=%b exp=1", stallreq_o); end
    sram_ack = 1'b1; sram_rdata = 32'h3401_1100;
    @(negedge clk);
    n_cmp++; if (if_ready !== 1'b1 || if_rdata !== 32'h3401_1100) begin n_bad++; $display("FAIL fetch_done got rdy=%b data=%h exp=1/34011100", if_ready, if_rdata); end
    n_cmp++; if (stallreq_o !== 1'b0 || err_o !== 1'b0) begin n_bad++; $display("FAIL fetch_done_flags got stall=%b err=%b exp=0/0", stallreq_o, err_o); end
    if_req = 1'b0; sram_ack = 1'b0; sram_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_cmp++; if (if_ready !== 1'b0 || if_rdata !== 32'h3401_1100 || sram_ce !== 1'b0) begin n_bad++; $display("FAIL fetch_hold got rdy=%b data=%h ce=%b exp=0/34011100/0", if_ready, if_rdata, sram_ce); end
  endtask

  task automatic test_contention;
    bit second_d;
    second_d = !rr_mode;
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_sel = 4'b0011; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++; if (state_dbg !== ST_D) begin n_bad++; $display("FAIL cont_first got=%0d exp=2", state_dbg); end
    n_cmp++; if (sram_we !== 1'b1 || sram_sel !== 4'b0011 || sram_addr !== 32'h200 || sram_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL cont_store_cmd got we=%b sel=%h a=%h wd=%h", sram_we, sram_sel, sram_addr, sram_wdata); end
    sram_ack = 1'b1; sram_rdata = 32'h9999_9999;
    @(negedge clk);
    n_cmp++; if (d_ready !== 1'b1 || d_rdata !== 32'h0 || if_ready !== 1'b0) begin n_bad++; $display("FAIL cont_store_done got rdy=%b%b data=%h exp=10/0", d_ready, if_ready, d_rdata); end
    n_cmp++; if (stallreq_o !== 1'b1) begin n_bad++; $display("FAIL cont_if_stall got=%b exp=1", stallreq_o); end
    d_we = 1'b0; d_addr = 32'h300; d_sel = 4'hF; sram_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (state_dbg !== (second_d ? ST_D : ST_IF)) begin n_bad++; $display("FAIL cont_second got=%0d exp=%0d", state_dbg, second_d ? ST_D : ST_IF); end
    n_cmp++; if (sram_addr !== (second_d ? 32'h300 : 32'h104) || sram_we !== 1'b0) begin n_bad++; $display("FAIL cont_second_cmd got a=%h we=%b", sram_addr, sram_we); end
    sram_ack = 1'b1; sram_rdata = 32'h1111_2222;
    @(negedge clk);
    n_cmp++; if (d_ready !== second_d || if_ready !== !second_d) begin n_bad++; $display("FAIL cont_second_done got d/if=%b%b", d_ready, if_ready); end
    n_cmp++; if ((second_d ? d_rdata : if_rdata) !== 32'h1111_2222) begin n_bad++; $display("FAIL cont_second_data got=%h exp=11112222", second_d ? d_rdata : if_rdata); end
    if (second_d) d_req = 1'b0; else if_req = 1'b0;
    sram_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (state_dbg !== (second_d ? ST_IF : ST_D)) begin n_bad++; $display("FAIL cont_third got=%0d", state_dbg); end
    n_cmp++; if (sram_addr !== (second_d ? 32'h104 : 32'h300)) begin n_bad++; $display("FAIL cont_third_addr got=%h", sram_addr); end
    sram_ack = 1'b1; sram_rdata = 32'h5555_6666;
    @(negedge clk);
    n_cmp++; if (d_ready !== !second_d || if_ready !== second_d) begin n_bad++; $display("FAIL cont_third_done got d/if=%b%b", d_ready, if_ready); end
    n_cmp++; if ((second_d ? if_rdata : d_rdata) !== 32'h5555_6666) begin n_bad++; $display("FAIL cont_third_data got=%h exp=55556666", second_d ? if_rdata : d_rdata); end
    if_req = 1'b0; d_req = 1'b0; sram_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    bit exp_d;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; d_sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      exp_d = rr_mode ? (i % 2 == 0) : 1'b1;
      @(negedge clk);
      n_cmp++; if (state_dbg !== (exp_d ? ST_D : ST_IF)) begin n_bad++; $display("FAIL rr_grant%0d got=%0d exp=%0d", i, state_dbg, exp_d ? ST_D : ST_IF); end
      sram_ack = 1'b1; sram_rdata = 32'hA5A5_0000 + i;
      @(negedge clk);
      n_cmp++; if (d_ready !== exp_d || if_ready !== !exp_d) begin n_bad++; $display("FAIL rr_done%0d got d/if=%b%b exp=%b%b", i, d_ready, if_ready, exp_d, !exp_d); end
      sram_ack = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; d_sel = 4'hF; sram_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (state_dbg !== ST_D) begin n_bad++; $display("FAIL to_grant got=%0d exp=2", state_dbg); end
    for (int i = 0; i < MAX_WAIT - 1; i++) begin
      @(negedge clk);
      n_cmp++; if (d_ready !== 1'b0 || err_o !== 1'b0) begin n_bad++; $display("FAIL to_early%0d got rdy=%b err=%b exp=0/0", i, d_ready, err_o); end
    end
    @(negedge clk);
    n_cmp++; if (d_ready !== 1'b1 || err_o !== 1'b1 || d_rdata !== 32'h0) begin n_bad++; $display("FAIL to_expire got rdy=%b err=%b data=%h exp=1/1/0", d_ready, err_o, d_rdata); end
    d_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (d_ready !== 1'b0 || err_o !== 1'b0 || sram_ce !== 1'b0) begin n_bad++; $display("FAIL to_after got rdy=%b err=%b ce=%b exp=000", d_ready, err_o, sram_ce); end
    // ack in the final counted cycle wins over the timeout
    d_req = 1'b1; d_addr = 32'h704;
    @(negedge clk);
    for (int i = 0; i < MAX_WAIT - 1; i++) begin
      @(negedge clk);
      n_cmp++; if (d_ready !== 1'b0 || err_o !== 1'b0) begin n_bad++; $display("FAIL to_ack_early%0d got rdy=%b err=%b exp=0/0", i, d_ready, err_o); end
    end
    sram_ack = 1'b1; sram_rdata = 32'hCAFE_0001;
    @(negedge clk);
    n_cmp++; if (d_ready !== 1'b1 || err_o !== 1'b0 || d_rdata !== 32'hCAFE_0001) begin n_bad++; $display("FAIL to_ack_wins got rdy=%b err=%b data=%h exp=1/0/cafe0001", d_ready, err_o, d_rdata); end
    d_req = 1'b0; sram_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    if_req = 1'b1; if_addr = 32'h800;
    @(negedge clk);
    n_cmp++; if (state_dbg !== ST_IF || sram_ce !== 1'b1) begin n_bad++; $display("FAIL midrst_grant got st=%0d ce=%b exp=1/1", state_dbg, sram_ce); end
    rst = 1'b0; sram_ack = 1'b1; sram_rdata = 32'h1234_5678;
    #1;
    n_cmp++; if (stallreq_o !== 1'b0) begin n_bad++; $display("FAIL midrst_stall got=%b exp=0", stallreq_o); end
    @(negedge clk);
    n_cmp++; if (if_ready !== 1'b0 || sram_ce !== 1'b0 || state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL midrst_abort got rdy=%b ce=%b st=%0d exp=0/0/0", if_ready, sram_ce, state_dbg); end
    n_cmp++; if (if_rdata !== 32'h0) begin n_bad++; $display("FAIL midrst_rdata got=%h exp=0", if_rdata); end
    rst = 1'b1; if_req = 1'b0; sram_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    test_reset;
    test_fetch;
    test_contention;
    test_round_robin;
    test_timeout;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port unified SRAM between the instruction-fetch port (pc_reg/if_id side) and the data port (MEM stage load/store side).
- Grants one requester at a time and holds registered address/control stable until the SRAM acknowledges.
- Returns read data and a one-cycle ready pulse to the granted requester.
- Raises a stall request to ctrl while any requester is waiting.
- Includes a bounded wait timeout so a missing SRAM ack cannot hang the pipeline.

Parameters:
MAX_WAIT, 15, cycles in an access state without sram_ack before timeout (range 2..255)
ADDR_W, 32, address width of all ports

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
if_req  in  1  instruction fetch request (rom_ce equivalent)
if_addr  in  ADDR_W  fetch address
if_rdata  out  32  fetched instruction, valid when if_ready=1
if_ready  out  1  one-cycle completion pulse for fetch
d_req  in  1  data access request (ram_ce equivalent)
d_we  in  1  1 = store, 0 = load
d_sel  in  4  byte lane select
d_addr  in  ADDR_W  data address
d_wdata  in  32  store data
d_rdata  out  32  load data, valid when d_ready=1
d_ready  out  1  one-cycle completion pulse for data
sram_ce  out  1  SRAM access enable
sram_we  out  1  SRAM write enable
sram_sel  out  4  SRAM byte lanes
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  32  SRAM write data
sram_rdata  in  32  SRAM read data, valid with sram_ack
sram_ack  in  1  SRAM completion, any latency >= 1 cycle after sram_ce rises
stallreq_o  out  1  stall request to ctrl
err_o  out  1  one-cycle timeout pulse

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, wait counter=0, last_grant=IF.
  - All outputs 0, including if_rdata/d_rdata.
  - Applies mid-access: no ready pulse is issued, sram_ce drops the next cycle.
- States:
  - IDLE: no access in flight.
  - IF_ACC: fetch access in flight.
  - D_ACC: data access in flight.
- Grant, evaluated in IDLE only:
  - d_req=1 goes to D_ACC, otherwise if_req=1 goes to IF_ACC.
  - Data has fixed priority because it belongs to the older instruction.
  - On grant, register the winner's addr, we, sel and wdata into the sram_* outputs and set sram_ce=1 on the same edge.
  - For IF grants: sram_we=0, sram_sel=4'b1111.
- In IF_ACC/D_ACC:
  - sram_* stay constant; counter increments each cycle.
  - sram_ack=1: capture sram_rdata into the granted rdata register (stores write 0 to d_rdata), pulse the granted ready for 1 cycle, clear sram_ce, clear counter, go to IDLE.
- Latency: the earliest completion is a ready pulse 2 cycles after req is sampled in IDLE (grant edge, then ack edge). A new grant can occur on the cycle after a ready pulse.
- Timeout: counter reaching MAX_WAIT-1 without ack completes the access as if acked, with rdata=0. err_o pulses simultaneously with ready.
- Ack arriving on the timeout cycle: ack wins; err_o=0 and real data is returned.
- Requesters hold req and its qualifiers stable until their ready pulse. A req dropped mid-access is ignored: the access completes and the ready is still pulsed.
- if_rdata/d_rdata hold their last value between pulses.
- stallreq_o = (if_req & ~if_ready) | (d_req & ~d_ready), combinational. It is 0 during reset.
- sram_ack in IDLE is ignored.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined:
  - A last_grant register updates on every grant.
  - When both reqs are high in IDLE, grant the port not granted last; a single req is granted directly.
  - Reset value of last_grant = IF, so the first contention goes to data.
- Undefined: fixed data-over-IF priority; last_grant logic is absent.

Test Plan:
- Reset: hold rst=0 for 3 cycles with if_req=d_req=1 -> all outputs 0, no sram_ce; after release, first grant is data.
- Fetch: if_req=1, if_addr=0x0000_0100, sram_ack 1 cycle after sram_ce, sram_rdata=0x3401_1100 -> sram_addr=0x100, sram_we=0, sram_sel=F; if_ready pulses once with if_rdata=0x3401_1100; stallreq_o=1 until the pulse.
- Contention: both reqs high, d_we=1, d_addr=0x200, d_sel=4'b0011, d_wdata=0xDEAD_BEEF -> data served first (sram_we=1, sram_sel=3), then fetch next; fixed mode keeps favouring data if it re-requests.
- Round-robin (ARB_ROUND_ROBIN_EN): both reqs continuously high, ack latency 1 -> grants alternate D, IF, D, IF.
- Timeout: d_req load, sram_ack never asserted, MAX_WAIT=15 -> after 15 cycles in D_ACC, d_ready=1, d_rdata=0, err_o=1 for one cycle; ack on the 15th cycle -> err_o=0 and data returned.
- Reset mid-access: rst=0 while in IF_ACC -> no if_ready pulse, sram_ce=0 next cycle, state IDLE.
